// File: rtl/dmem_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// dmem_port_arbiter_pkg
//   Shared definitions for the data-memory port arbiter: ownership state
//   encoding, default arbitration limits, and a counter-width helper.
// -----------------------------------------------------------------------------
package dmem_port_arbiter_pkg;

    typedef enum logic {
        CPU_OWN  = 1'b0,
        HOST_OWN = 1'b1
    } arb_state_e;

    localparam int DEF_STARVE_LIMIT = 8;
    localparam int DEF_MAX_BURST    = 8;

    // Bits needed to hold 0..max_val; never narrower than one bit so that
    // a limit of 1 (max_val = 0) still yields a legal vector.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/dmem_port_arbiter_arb_sat_counter.sv
// -----------------------------------------------------------------------------
// arb_sat_counter
//   Up-counter that sticks at MAX_VAL. Synchronous clear wins over increment.
// Ports
//   clk    in  clock
//   rst_n  in  asynchronous active-low reset
//   clr_i  in  synchronous clear
//   inc_i  in  increment request (ignored once at MAX_VAL)
//   cnt_o  out current count
// -----------------------------------------------------------------------------
module arb_sat_counter
    import dmem_port_arbiter_pkg::*;
#(
    parameter int MAX_VAL = 7,
    parameter int W       = cnt_width(MAX_VAL)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != W'(MAX_VAL))) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/dmem_port_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_port_arbiter
//   Shares the single-port data memory between the pipeline MEM stage and a
//   host loader. The CPU has priority; a starvation counter bounds how long
//   the host waits, and a beat counter bounds how long the host keeps the port.
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   CPU_OWN  | memory driven by MEM stage; host waits (host_ready=0)
//   HOST_OWN | memory driven by host; pipeline frozen (cpu_stall=1)
//
// Ports
//   clk, reset                 clock, asynchronous active-low reset
//   cpu_rd/wr/addr/wdata       MEM-stage access request
//   cpu_rdata, cpu_stall       load data back to MEM/WB, pipeline freeze
//   host_valid/we/last/addr/wdata, host_ready
//                              host beat handshake (accepted on valid&ready)
//   host_rdata, host_rvalid    registered host read data, one cycle after beat
//   mem_re/we/addr/wdata       to data_memory
//   mem_rdata                  combinational read data from data_memory
// -----------------------------------------------------------------------------
module dmem_port_arbiter
    import dmem_port_arbiter_pkg::*;
#(
    parameter int AW           = 64,
    parameter int DW           = 64,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
    parameter int MAX_BURST    = DEF_MAX_BURST
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          cpu_rd,
    input  logic          cpu_wr,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_stall,

    input  logic          host_valid,
    input  logic          host_we,
    input  logic          host_last,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic          host_ready,
    output logic [DW-1:0] host_rdata,
    output logic          host_rvalid,

    output logic          mem_re,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam int WAIT_MAX = STARVE_LIMIT - 1;
    localparam int BEAT_MAX = MAX_BURST - 1;
    localparam int WAIT_W   = cnt_width(WAIT_MAX);
    localparam int BEAT_W   = cnt_width(BEAT_MAX);

    arb_state_e state_q;
    arb_state_e state_d;

    logic [WAIT_W-1:0] wait_cnt;
    logic [BEAT_W-1:0] beat_cnt;

    logic host_own;
    logic cpu_req;
    logic wait_at_limit;
    logic beat_at_limit;
    logic host_grant;
    logic host_exit;
    logic host_beat;
    logic host_rd_beat;

    logic          host_rvalid_q;
    logic [DW-1:0] host_rdata_q;

    assign host_own      = (state_q == HOST_OWN);
    assign cpu_req       = cpu_rd | cpu_wr;
    assign wait_at_limit = (wait_cnt == WAIT_W'(WAIT_MAX));
    assign beat_at_limit = (beat_cnt == BEAT_W'(BEAT_MAX));
    // host_ready is 1 throughout HOST_OWN, so any valid there is an accepted beat
    assign host_beat     = host_own & host_valid;
    assign host_rd_beat  = host_beat & ~host_we;

    always_comb begin
        state_d    = state_q;
        host_grant = 1'b0;
        host_exit  = 1'b0;
        unique case (state_q)
            CPU_OWN: begin
                // Forced grant: the CPU access of this cycle still completes,
                // the stall only begins once the state has flipped.
                if (host_valid && (!cpu_req || wait_at_limit)) begin
                    host_grant = 1'b1;
                    state_d    = HOST_OWN;
                end
            end
            HOST_OWN: begin
                // No idle hold: a gap in host_valid hands the port straight back.
                if (!host_valid || host_last || beat_at_limit) begin
                    host_exit = 1'b1;
                    state_d   = CPU_OWN;
                end
            end
            default: state_d = CPU_OWN;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= CPU_OWN;
        end else begin
            state_q <= state_d;
        end
    end

    arb_sat_counter #(
        .MAX_VAL (WAIT_MAX),
        .W       (WAIT_W)
    ) u_wait_cnt (
        .clk   (clk),
        .rst_n (reset),
        .clr_i (host_own | ~host_valid | host_grant),
        .inc_i (host_valid & cpu_req),
        .cnt_o (wait_cnt)
    );

    arb_sat_counter #(
        .MAX_VAL (BEAT_MAX),
        .W       (BEAT_W)
    ) u_beat_cnt (
        .clk   (clk),
        .rst_n (reset),
        .clr_i (~host_own | host_exit),
        .inc_i (host_beat),
        .cnt_o (beat_cnt)
    );

    // Port mux. Strobes are qualified by reset so that an asserted reset
    // blocks a memory write in the same cycle even while cpu_wr is high.
    always_comb begin
        mem_re     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = cpu_addr;
        mem_wdata  = cpu_wdata;
        cpu_rdata  = '0;
        cpu_stall  = 1'b0;
        host_ready = 1'b0;
        if (host_own) begin
            mem_re     = reset & host_valid & ~host_we;
            mem_we     = reset & host_valid & host_we;
            mem_addr   = host_addr;
            mem_wdata  = host_wdata;
            cpu_stall  = 1'b1;
            host_ready = 1'b1;
        end else begin
            mem_re    = reset & cpu_rd;
            mem_we    = reset & cpu_wr;
            cpu_rdata = mem_rdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            host_rvalid_q <= 1'b0;
            host_rdata_q  <= '0;
        end else begin
            host_rvalid_q <= host_rd_beat;
            if (host_rd_beat) begin
                host_rdata_q <= mem_rdata;
            end
        end
    end

    assign host_rvalid = host_rvalid_q;
    assign host_rdata  = host_rdata_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
module tb_dmem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_rd, cpu_wr;
    logic [63:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_stall;
    logic        host_valid, host_we, host_last;
    logic [63:0] host_addr, host_wdata, host_rdata;
    logic        host_ready, host_rvalid;
    logic        mem_re, mem_we;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    dmem_port_arbiter #(
        .AW(64), .DW(64), .STARVE_LIMIT(8), .MAX_BURST(8)
    ) dut (
        .clk(clk), .reset(reset),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .host_valid(host_valid), .host_we(host_we), .host_last(host_last),
        .host_addr(host_addr), .host_wdata(host_wdata), .host_ready(host_ready),
        .host_rdata(host_rdata), .host_rvalid(host_rvalid),
        .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // Sparse memory model: unwritten words read a fixed pattern.
    bit [63:0] tb_mem [256];
    bit        tb_wr  [256];

    function automatic logic [63:0] mem_init(input int idx);
        return (idx == 3) ? 64'hDEAD : (64'hA000 + 64'(idx));
    endfunction

    function automatic logic [63:0] peek(input logic [63:0] a);
        int idx;
        idx = int'(a[10:3]);
        return tb_wr[idx] ? tb_mem[idx] : mem_init(idx);
    endfunction

    always @(posedge clk) begin
        if (mem_we) begin
            tb_mem[mem_addr[10:3]] <= mem_wdata;
            tb_wr[mem_addr[10:3]]  <= 1'b1;
        end
    end

    assign mem_rdata = peek(mem_addr);

    int n_tot = 0;
    int n_bad = 0;
    logic [63:0] exp_q [$];
    int ready_cnt = 0;
    int stall_cnt = 0;
    logic prev_rd = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Output monitor: host read returns exactly one cycle after each accepted
    // read beat and must match the scoreboard head.
    always @(negedge clk) begin
        if (host_ready) ready_cnt++;
        if (cpu_stall)  stall_cnt++;
        chk("rvalid_timing", 64'(host_rvalid), 64'(prev_rd));
        if (host_rvalid) begin
            chk("rd_q_nonempty", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) chk("host_rdata", host_rdata, exp_q.pop_front());
        end
        prev_rd = host_valid & host_ready & ~host_we & reset;
    end

    task automatic host_beat(input logic we, input logic [63:0] a, input logic [63:0] d,
                             input logic last, output int n);
        n = 0;
        host_valid = 1'b1; host_we = we; host_addr = a; host_wdata = d; host_last = last;
        if (!we) exp_q.push_back(peek(a));
        @(negedge clk);
        while (!host_ready && n < 64) begin
            @(negedge clk);
            n++;
        end
        chk("beat_ready", 64'(host_ready), 64'd1);
        @(posedge clk); #1;
        host_valid = 1'b0; host_last = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    int n, r0, s0;

    initial begin
        cpu_rd = 0; cpu_wr = 0; cpu_addr = 0; cpu_wdata = 0;
        host_valid = 0; host_we = 0; host_last = 0; host_addr = 0; host_wdata = 0;
        reset = 1'b1;
        #2 reset = 1'b0;

        // 1: reset holds everything quiet even with requests pending
        cpu_wr = 1; cpu_addr = 64'd2000; cpu_wdata = 64'h99;
        host_valid = 1; host_we = 1; host_addr = 8; host_wdata = 64'h77;
        repeat (2) @(negedge clk);
        chk("t1_stall", 64'(cpu_stall), 0);
        chk("t1_ready", 64'(host_ready), 0);
        chk("t1_mem_we", 64'(mem_we), 0);
        chk("t1_mem_re", 64'(mem_re), 0);
        chk("t1_rvalid", 64'(host_rvalid), 0);
        chk("t1_rdata", host_rdata, 0);
        host_valid = 0; cpu_wr = 0;
        reset = 1'b1;
        chk("t1_nowrite", peek(64'd2000), mem_init(250));
        @(posedge clk); #1;
        cpu_rd = 1; cpu_addr = 256;
        @(negedge clk);
        chk("t1_cpu_re", 64'(mem_re), 1);
        chk("t1_cpu_rdata", cpu_rdata, 64'hA020);
        chk("t1_cpu_nostall", 64'(cpu_stall), 0);
        cpu_rd = 0;

        // 2: idle CPU, 3-beat host write burst
        @(posedge clk); #1;
        r0 = ready_cnt; s0 = stall_cnt;
        host_beat(1, 0, 1, 0, n);  chk("t2_wait1", n, 1);
        host_beat(1, 8, 2, 0, n);  chk("t2_wait2", n, 0);
        host_beat(1, 16, 3, 1, n); chk("t2_wait3", n, 0);
        chk("t2_ready_cycles", ready_cnt - r0, 3);
        chk("t2_stall_cycles", stall_cnt - s0, 3);
        @(negedge clk);
        chk("t2_back_cpu", 64'(cpu_stall), 0);
        chk("t2_mem0", peek(0), 1);
        chk("t2_mem8", peek(8), 2);
        chk("t2_mem16", peek(16), 3);

        // 3: CPU loads every cycle, host waits out the starvation limit
        @(posedge clk); #1;
        cpu_rd = 1;
        host_valid = 1; host_we = 1; host_addr = 40; host_wdata = 64'h55; host_last = 1;
        for (int k = 0; k < 8; k++) begin
            cpu_addr = 64'(256 + 8 * k);
            @(negedge clk);
            chk("t3_noready", 64'(host_ready), 0);
            chk("t3_ld", cpu_rdata, 64'hA020 + 64'(k));
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("t3_ready8", 64'(host_ready), 1);
        chk("t3_stall8", 64'(cpu_stall), 1);
        chk("t3_rdata0", cpu_rdata, 0);
        @(posedge clk); #1;
        host_valid = 0; host_last = 0;
        @(negedge clk);
        chk("t3_back_cpu", 64'(cpu_stall), 0);
        chk("t3_mem40", peek(40), 64'h55);
        cpu_rd = 0;

        // 4: 12-beat burst against a busy CPU, cut at 8 beats
        @(posedge clk); #1;
        cpu_rd = 1; cpu_addr = 256;
        for (int i = 0; i < 12; i++) begin
            host_beat(1, 64'(512 + 8 * i), 64'(256 + i), (i == 11), n);
            chk("t4_wait", n, (i == 0 || i == 8) ? 8 : 0);
        end
        cpu_rd = 0;
        for (int i = 0; i < 12; i++) chk("t4_mem", peek(64'(512 + 8 * i)), 64'(256 + i));

        // 5: host read burst while CPU store waits
        host_valid = 1; host_we = 0; host_addr = 24; host_last = 0;
        exp_q.push_back(64'hDEAD);
        @(negedge clk);
        chk("t5_grant_wait", 64'(host_ready), 0);
        @(posedge clk); #1;
        cpu_wr = 1; cpu_addr = 800; cpu_wdata = 64'h77;
        @(negedge clk);
        chk("t5_stall", 64'(cpu_stall), 1);
        chk("t5_mem_we", 64'(mem_we), 0);
        chk("t5_mem_re", 64'(mem_re), 1);
        @(posedge clk); #1;
        host_addr = 256; host_last = 1;
        exp_q.push_back(64'hA020);
        @(negedge clk);
        chk("t5_stall2", 64'(cpu_stall), 1);
        chk("t5_store_held", peek(800), mem_init(100));
        @(posedge clk); #1;
        host_valid = 0; host_last = 0;
        @(negedge clk);
        chk("t5_store_go", 64'(mem_we), 1);
        chk("t5_store_addr", mem_addr, 800);
        @(posedge clk); #1;
        cpu_wr = 0;
        chk("t5_store_done", peek(800), 64'h77);
        @(negedge clk);
        chk("t5_q_empty", 64'(exp_q.size()), 0);

        // 6: reset asserted during beat 2 of a write burst
        @(posedge clk); #1;
        host_beat(1, 1024, 64'hB0, 0, n);
        host_valid = 1; host_we = 1; host_addr = 1032; host_wdata = 64'hB1;
        @(negedge clk);
        chk("t6_ready_pre", 64'(host_ready), 1);
        #1 reset = 1'b0;
        #1;
        chk("t6_stall", 64'(cpu_stall), 0);
        chk("t6_ready", 64'(host_ready), 0);
        chk("t6_mem_we", 64'(mem_we), 0);
        chk("t6_mem_re", 64'(mem_re), 0);
        chk("t6_rvalid", 64'(host_rvalid), 0);
        @(posedge clk); #1;
        chk("t6_no_write", peek(1032), mem_init(129));
        chk("t6_keep_beat1", peek(1024), 64'hB0);
        @(negedge clk);
        host_valid = 0;
        reset = 1'b1;
        @(posedge clk); #1;
        cpu_rd = 1; cpu_addr = 1032;
        @(negedge clk);
        chk("t6_cpu_own", 64'(cpu_stall), 0);
        chk("t6_cpu_rd", cpu_rdata, mem_init(129));
        cpu_rd = 0;
        repeat (2) @(posedge clk);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
